// File: rtl/iir_pb_sequencer_if.sv
// Control bundle between the biquad sequencer and its datapath / host.
// Latency: none, wires only.
// Backpressure: none; start is a strobe and every control output is a one-cycle decode.
interface iir_pb_sequencer_if;
    logic       start;
    logic [2:0] controlS;
    logic [1:0] controlC;
    logic [2:0] controlZ;
    logic       en_acum1;
    logic       en_acum2;
    logic       en_acum3;
    logic       en_fk;
    logic       en_yk;
    logic       shift;
    logic       busy;
    logic       done;
    logic       overrun;

    // Host / datapath side: issues start, consumes the control word.
    modport master (
        output start,
        input  controlS, controlC, controlZ,
        input  en_acum1, en_acum2, en_acum3, en_fk, en_yk,
        input  shift, busy, done, overrun
    );

    // Sequencer side.
    modport slave (
        input  start,
        output controlS, controlC, controlZ,
        output en_acum1, en_acum2, en_acum3, en_fk, en_yk,
        output shift, busy, done, overrun
    );
endinterface

// File: rtl/iir_pb_sequencer.sv
// Moore sequencer driving a shared-multiplier biquad: five MAC steps then a state-variable shift.
// Latency: done pulses 6 cycles after the edge that accepts start; one sample per 7 cycles at best.
// Backpressure: none; start outside IDLE is dropped and latched into the sticky overrun flag.
module iir_pb_sequencer (
    input  logic              clk,
    input  logic              reset,
    iir_pb_sequencer_if.slave sq
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M1   = 3'd1,
        M2   = 3'd2,
        M3   = 3'd3,
        M4   = 3'd4,
        M5   = 3'd5,
        UPD  = 3'd6
    } state_e;

    // Held as raw bits so the unused code 3'd7 is representable and decodes to a safe return.
    logic [2:0] state_q;
    state_e     state_d;
    logic       overrun_q;
    logic       overrun_d;

    logic [2:0] ctrl_s;
    logic [1:0] ctrl_c;
    logic [2:0] ctrl_z;
    logic       en_acum1;
    logic       en_acum2;
    logic       en_acum3;
    logic       en_fk;
    logic       en_yk;
    logic       shift;
    logic       done;

    // State and sticky error flag; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state plus Moore decode of the control word; start only steers the next state.
    always_comb begin
        state_d  = IDLE;
        ctrl_s   = 3'b000;
        ctrl_c   = 2'b00;
        ctrl_z   = 3'b000;
        en_acum1 = 1'b0;
        en_acum2 = 1'b0;
        en_acum3 = 1'b0;
        en_fk    = 1'b0;
        en_yk    = 1'b0;
        shift    = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sq.start) begin
                    state_d = M1;
                end
            end
            // acum1 <= Uk + auno*fk1
            M1: begin
                ctrl_s   = 3'b001;
                ctrl_c   = 2'b01;
                ctrl_z   = 3'b001;
                en_acum1 = 1'b1;
                state_d  = M2;
            end
            // fk <= acum1 + ados*fk2
            M2: begin
                ctrl_s  = 3'b010;
                ctrl_c  = 2'b10;
                ctrl_z  = 3'b011;
                en_fk   = 1'b1;
                state_d = M3;
            end
            // acum2 <= bcero*fk
            M3: begin
                ctrl_s   = 3'b011;
                ctrl_c   = 2'b11;
                ctrl_z   = 3'b000;
                en_acum2 = 1'b1;
                state_d  = M4;
            end
            // acum3 <= acum2 + buno*fk1
            M4: begin
                ctrl_s   = 3'b100;
                ctrl_c   = 2'b01;
                ctrl_z   = 3'b100;
                en_acum3 = 1'b1;
                state_d  = M5;
            end
            // yk <= acum3 + bdos*fk2
            M5: begin
                ctrl_s  = 3'b101;
                ctrl_c  = 2'b10;
                ctrl_z  = 3'b101;
                en_yk   = 1'b1;
                state_d = UPD;
            end
            // fk2 <= fk1, fk1 <= fk; yk already holds the new sample
            UPD: begin
                shift   = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Any start seen while not idle (including UPD and stray codes) is an overrun.
    always_comb begin
        overrun_d = overrun_q | (sq.start & (state_q != IDLE));
    end

    assign sq.controlS = ctrl_s;
    assign sq.controlC = ctrl_c;
    assign sq.controlZ = ctrl_z;
    assign sq.en_acum1 = en_acum1;
    assign sq.en_acum2 = en_acum2;
    assign sq.en_acum3 = en_acum3;
    assign sq.en_fk    = en_fk;
    assign sq.en_yk    = en_yk;
    assign sq.shift    = shift;
    assign sq.done     = done;
    assign sq.busy     = (state_q != IDLE);
    assign sq.overrun  = overrun_q;

endmodule

// File: tb/tb_iir_pb_sequencer.sv
// Bench for the biquad sequencer: per-cycle control-word scoreboard plus a datapath driven by the DUT.
// Latency: expected words are pushed at the driving negedge and checked 1 time unit after the next posedge.
// Backpressure: none; yk is checked against a direct biquad recurrence whenever done is seen.
module tb_iir_pb_sequencer;

    logic clk = 1'b0;
    logic reset;

    iir_pb_sequencer_if sq ();

    iir_pb_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .sq    (sq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] s;
        logic [1:0] c;
        logic [2:0] z;
        logic [4:0] en;    // {acum1, fk, acum2, acum3, yk}
        logic       shift;
        logic       done;
        logic       busy;
        logic       ovr;
    } exp_t;

    int     checks;
    int     errors;
    int     done_cnt;
    exp_t   expq[$];
    longint yq[$];

    // Reference model state: position inside the 7-cycle pass and the sticky flag.
    int     m_phase;
    logic   m_ovr;
    longint r_f1;
    longint r_f2;

    localparam int     Q  = 14;
    localparam longint A1 = 14746;   //  0.9  (feedback taken with sign folded in)
    localparam longint A2 = -6554;   // -0.4
    localparam longint B0 = 4096;
    localparam longint B1 = 8192;
    localparam longint B2 = 4096;

    function automatic longint qmul(input longint c, input longint x);
        return (c * x) >>> Q;
    endfunction

    // ---------------- datapath driven by the sequencer ----------------
    longint uk;
    longint acum1, acum2, acum3, fk, fk1, fk2, yk;
    longint coef, stv, addend, dp_sum;

    always_comb begin
        coef = 0;
        case (sq.controlS)
            3'd1:    coef = A1;
            3'd2:    coef = A2;
            3'd3:    coef = B0;
            3'd4:    coef = B1;
            3'd5:    coef = B2;
            default: coef = 0;
        endcase
        stv = 0;
        case (sq.controlC)
            2'd1:    stv = fk1;
            2'd2:    stv = fk2;
            2'd3:    stv = fk;
            default: stv = 0;
        endcase
        addend = 0;
        case (sq.controlZ)
            3'd1:    addend = uk;
            3'd2:    addend = yk;
            3'd3:    addend = acum1;
            3'd4:    addend = acum2;
            3'd5:    addend = acum3;
            default: addend = 0;
        endcase
        dp_sum = addend + qmul(coef, stv);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acum1 <= 0; acum2 <= 0; acum3 <= 0;
            fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0;
        end else begin
            if (sq.en_acum1) acum1 <= dp_sum;
            if (sq.en_fk)    fk    <= dp_sum;
            if (sq.en_acum2) acum2 <= dp_sum;
            if (sq.en_acum3) acum3 <= dp_sum;
            if (sq.en_yk)    yk    <= dp_sum;
            if (sq.shift) begin
                fk2 <= fk1;
                fk1 <= fk;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic exp_t cur();
        exp_t g;
        g.s     = sq.controlS;
        g.c     = sq.controlC;
        g.z     = sq.controlZ;
        g.en    = {sq.en_acum1, sq.en_fk, sq.en_acum2, sq.en_acum3, sq.en_yk};
        g.shift = sq.shift;
        g.done  = sq.done;
        g.busy  = sq.busy;
        g.ovr   = sq.overrun;
        return g;
    endfunction

    task automatic chk_ctrl(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got S=%b C=%b Z=%b en=%b sh=%b dn=%b bz=%b ov=%b expected S=%b C=%b Z=%b en=%b sh=%b dn=%b bz=%b ov=%b",
                     name, got.s, got.c, got.z, got.en, got.shift, got.done, got.busy, got.ovr,
                     exp.s, exp.c, exp.z, exp.en, exp.shift, exp.done, exp.busy, exp.ovr);
        end
    endtask

    // Control word required in each position of a pass (0 = idle, 6 = update).
    function automatic exp_t expect_for(input int ph, input logic ovr);
        exp_t e;
        e      = '0;
        e.busy = (ph != 0);
        e.ovr  = ovr;
        case (ph)
            1: begin e.s = 3'd1; e.c = 2'd1; e.z = 3'd1; e.en = 5'b10000; end
            2: begin e.s = 3'd2; e.c = 2'd2; e.z = 3'd3; e.en = 5'b01000; end
            3: begin e.s = 3'd3; e.c = 2'd3; e.z = 3'd0; e.en = 5'b00100; end
            4: begin e.s = 3'd4; e.c = 2'd1; e.z = 3'd4; e.en = 5'b00010; end
            5: begin e.s = 3'd5; e.c = 2'd2; e.z = 3'd5; e.en = 5'b00001; end
            6: begin e.shift = 1'b1; e.done = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock of stimulus: drive start at the negedge, advance the model, queue the expectation.
    task automatic step(input logic s, input longint u);
        longint f;
        @(negedge clk);
        sq.start = s;
        if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                uk      = u;
                f       = u + qmul(A1, r_f1) + qmul(A2, r_f2);
                yq.push_back(qmul(B0, f) + qmul(B1, r_f1) + qmul(B2, r_f2));
                r_f2    = r_f1;
                r_f1    = f;
            end
        end else begin
            if (s) m_ovr = 1'b1;
            m_phase = (m_phase == 6) ? 0 : m_phase + 1;
        end
        expq.push_back(expect_for(m_phase, m_ovr));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Assert reset mid-cycle and check that everything drops at once, then release before a negedge.
    task automatic apply_reset();
        settle();
        reset    = 1'b0;
        sq.start = 1'b0;
        m_phase  = 0;
        m_ovr    = 1'b0;
        r_f1     = 0;
        r_f2     = 0;
        yq.delete();
        #1;
        chk_ctrl("reset_ctrl", cur(), exp_t'(0));
        chk("reset_busy", sq.busy, 0);
        chk("reset_overrun", sq.overrun, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    function automatic longint rnd_u();
        return longint'($urandom_range(0, 32767)) - 16384;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk_ctrl("ctrl", cur(), e);
            end
            if (sq.done === 1'b1) begin
                done_cnt++;
                if (yq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL yk_unexpected: got done with yk=%0d expected no done", yk);
                end else begin
                    chk("yk", yk, yq.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        reset    = 1'b0;
        sq.start = 1'b0;
        uk       = 0;
        m_phase  = 0;
        m_ovr    = 1'b0;
        r_f1     = 0;
        r_f2     = 0;

        apply_reset();

        // Single pulse: five MAC tuples in order, then update, then idle.
        step(1'b1, 1000);
        repeat (7) step(1'b0, 0);

        // Second start while in M3: sequence continues, overrun latches and stays.
        step(1'b1, -500);
        step(1'b0, 0);
        step(1'b0, 0);
        step(1'b1, 0);
        repeat (6) step(1'b0, 0);
        settle();
        chk("overrun_sticky", sq.overrun, 1);

        // start held high for 20 cycles: done at 6, 13, 20.
        apply_reset();
        d0 = done_cnt;
        repeat (20) step(1'b1, rnd_u());
        settle();
        chk("held_done_count", done_cnt - d0, 3);
        chk("held_overrun", sq.overrun, 1);
        step(1'b0, 0);

        // Reset in M4 aborts with no done; afterwards a clean pass.
        apply_reset();
        step(1'b1, 3000);
        repeat (3) step(1'b0, 0);
        d0 = done_cnt;
        apply_reset();
        chk("abort_no_done", done_cnt - d0, 0);
        step(1'b1, 2500);
        repeat (7) step(1'b0, 0);
        settle();
        chk("clean_after_abort_overrun", sq.overrun, 0);

        // Stray state code: safe decode and return to IDLE.
        @(negedge clk);
        force dut.state_q = 3'b111;
        #1;
        chk("illegal_en", {sq.en_acum1, sq.en_fk, sq.en_acum2, sq.en_acum3, sq.en_yk, sq.shift, sq.done}, 0);
        chk("illegal_sel", {sq.controlS, sq.controlC, sq.controlZ}, 0);
        chk("illegal_next", dut.state_d, 0);
        #1;
        release dut.state_q;
        settle();
        chk("illegal_recover_busy", sq.busy, 0);

        // Randomized starts and samples.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), rnd_u());
        end
        repeat (7) step(1'b0, 0);

        // Unit impulse through the biquad for 64 samples.
        apply_reset();
        for (int k = 0; k < 64; k++) begin
            step(1'b1, (k == 0) ? 64'sd16384 : 64'sd0);
            repeat (6) step(1'b0, 0);
        end
        settle();
        settle();
        chk("yk_pending", yq.size(), 0);
        chk("ctrl_pending", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
